// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state type, default geometry and the address-field
// helper used by the cache read-path controller.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    READ,
    RESP
  } state_e;

  localparam int unsigned NUM_WAYS_DEF    = 512;
  localparam int unsigned DATA_WIDTH_DEF  = 32;
  localparam int unsigned ADDR_WIDTH_DEF  = 32;
  localparam int unsigned OFFSET_BITS_DEF = 2;
  localparam int unsigned INDEX_BITS_DEF  = 6;
  localparam int unsigned CNT_WIDTH_DEF   = 32;
  localparam int unsigned TAG_BITS_DEF    = ADDR_WIDTH_DEF - INDEX_BITS_DEF - OFFSET_BITS_DEF;

  // Widest address the extract helper handles; narrower addresses are zero-extended.
  localparam int unsigned ADDR_MAX = 64;

  function automatic logic [ADDR_MAX-1:0] addr_field(input logic [ADDR_MAX-1:0] addr,
                                                     input int unsigned        lsb,
                                                     input int unsigned        width);
    logic [ADDR_MAX-1:0] mask;
    if (width >= ADDR_MAX) mask = '1;
    else                   mask = (ADDR_MAX'(1) << width) - ADDR_MAX'(1);
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/hit_vector_check.sv
// hit_vector_check: combinational summary of the per-way tag-match vector
// (any way hit, more than one way hit).
module hit_vector_check #(
  parameter int unsigned NUM_WAYS = 512
) (
  input  logic [NUM_WAYS-1:0] hit_vec,
  output logic                any_hit,
  output logic                multi_hit
);

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign any_hit   = |hit_vec;
  assign multi_hit = |(hit_vec & (hit_vec - NUM_WAYS'(1)));

endmodule

// File: rtl/cache_read_ctrl.sv
// cache_read_ctrl: CPU read-path controller between the CPU and the way arrays.
// Optional multi-hit detection is enabled by defining CACHE_MULTI_HIT_CHECK_EN.
module cache_read_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned NUM_WAYS    = NUM_WAYS_DEF,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned OFFSET_BITS = OFFSET_BITS_DEF,
  parameter int unsigned INDEX_BITS  = INDEX_BITS_DEF,
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        req_valid,
  output logic                                        req_ready,
  input  logic [ADDR_WIDTH-1:0]                       req_addr,
  output logic                                        lookup_en,
  output logic [INDEX_BITS-1:0]                       lookup_index,
  output logic [ADDR_WIDTH-INDEX_BITS-OFFSET_BITS-1:0] lookup_tag,
  input  logic [NUM_WAYS-1:0]                         way_hit,
  output logic [NUM_WAYS-1:0]                         target_way,
  input  logic [DATA_WIDTH-1:0]                       read_data,
  output logic                                        resp_valid,
  input  logic                                        resp_ready,
  output logic [DATA_WIDTH-1:0]                       resp_data,
  output logic                                        resp_hit,
  output logic                                        resp_err,
  input  logic                                        stats_clr,
  output logic [CNT_WIDTH-1:0]                        hit_count,
  output logic [CNT_WIDTH-1:0]                        miss_count
);

  localparam int unsigned TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] index_q, index_d;
  logic [TAG_BITS-1:0]   tag_q, tag_d;
  logic [NUM_WAYS-1:0]   target_q, target_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  hit_q, hit_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

  logic                  any_hit, multi_hit;
  logic                  hit_ok, multi_err;
  logic [ADDR_MAX-1:0]   addr_ext, idx_field, tag_field;
  logic                  unused_bits;

  hit_vector_check #(
    .NUM_WAYS (NUM_WAYS)
  ) u_hit_check (
    .hit_vec   (way_hit),
    .any_hit   (any_hit),
    .multi_hit (multi_hit)
  );

`ifdef CACHE_MULTI_HIT_CHECK_EN
  assign hit_ok      = any_hit & ~multi_hit;
  assign multi_err   = multi_hit;
  assign unused_bits = ^{idx_field[ADDR_MAX-1:INDEX_BITS], tag_field[ADDR_MAX-1:TAG_BITS]};
`else
  assign hit_ok      = any_hit;
  assign multi_err   = 1'b0;
  assign unused_bits = ^{idx_field[ADDR_MAX-1:INDEX_BITS], tag_field[ADDR_MAX-1:TAG_BITS],
                         multi_hit};
`endif

  always_comb begin
    addr_ext                 = '0;
    addr_ext[ADDR_WIDTH-1:0] = req_addr;
  end

  assign idx_field = addr_field(addr_ext, OFFSET_BITS, INDEX_BITS);
  assign tag_field = addr_field(addr_ext, OFFSET_BITS + INDEX_BITS, TAG_BITS);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid)  state_d = LOOKUP;
      LOOKUP:  state_d = hit_ok ? READ : RESP;
      READ:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    lookup_en  = (state_q == LOOKUP);
    resp_valid = (state_q == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q    <= '0;
      tag_q      <= '0;
      target_q   <= '0;
      data_q     <= '0;
      hit_q      <= 1'b0;
      err_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      index_q    <= index_d;
      tag_q      <= tag_d;
      target_q   <= target_d;
      data_q     <= data_d;
      hit_q      <= hit_d;
      err_q      <= err_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // NOTE: every next-state value defaults to its register first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    index_d    = index_q;
    tag_d      = tag_q;
    target_d   = target_q;
    data_d     = data_q;
    hit_d      = hit_q;
    err_d      = err_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          index_d = idx_field[INDEX_BITS-1:0];
          tag_d   = tag_field[TAG_BITS-1:0];
        end
      end
      LOOKUP: begin
        if (hit_ok) begin
          target_d = way_hit;
          err_d    = 1'b0;
          if (~&hit_cnt_q) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
        end else begin
          target_d = '0;
          data_d   = '0;
          hit_d    = 1'b0;
          err_d    = multi_err;
          if (~&miss_cnt_q) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
        end
      end
      READ: begin
        data_d = read_data;
        hit_d  = 1'b1;
      end
      RESP: begin
        if (resp_ready) begin
          target_d = '0;
          data_d   = '0;
          hit_d    = 1'b0;
          err_d    = 1'b0;
        end
      end
      default: ;
    endcase

    // Clear has priority over the increment computed above.
    if (stats_clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end
  end

  assign lookup_index = index_q;
  assign lookup_tag   = tag_q;
  assign target_way   = target_q;
  assign resp_data    = data_q;
  assign resp_hit     = hit_q;
  assign resp_err     = err_q;
  assign hit_count    = hit_cnt_q;
  assign miss_count   = miss_cnt_q;

endmodule
